// File: rtl/gfx_cmd_ctrl_pkg.sv
// gfx_pkg: shared opcodes, FSM states, widths and helpers for gfx_cmd_ctrl.
// Optional feature macro: GFX_CMD_CTRL_FILL_EN (adds the FILL state).
package gfx_pkg;

  localparam int SCORE_MAX = 999;
  localparam int TILE_AW   = 10;
  localparam int COLOR_W   = 3;

  typedef enum logic [3:0] {
    OP_WRITE_TILE = 4'h1,
    OP_SET_SCORE  = 4'h2,
    OP_ADD_SCORE  = 4'h3,
    OP_SET_STATE  = 4'h4,
    OP_FILL       = 4'h5
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2
`ifdef GFX_CMD_CTRL_FILL_EN
    ,ST_FILL  = 2'd3
`endif
  } fsm_state_e;

  typedef struct packed {
    logic [7:0] command;
    logic [7:0] db1;
    logic [7:0] db2;
  } cmd_hold_t;

  // Saturate an 11-bit score intermediate at SCORE_MAX
  function automatic logic [9:0] clamp_score(input logic [10:0] v);
    return (v > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : v[9:0];
  endfunction

endpackage

// File: rtl/gfx_cmd_ctrl_if.sv
// gfx_cmd_ctrl_if: command strobe, VGA read request, tile-memory port and status.
// master = command source / memory side, slave = gfx_cmd_ctrl.
interface gfx_cmd_ctrl_if;

  logic                          cmd_valid;
  logic [7:0]                    command;
  logic [7:0]                    databyte1;
  logic [7:0]                    databyte2;
  logic                          cmd_ready;
  logic                          re;
  logic [gfx_pkg::TILE_AW-1:0]   raddr;
  logic [gfx_pkg::TILE_AW-1:0]   mem_addr;
  logic [gfx_pkg::COLOR_W-1:0]   mem_wdata;
  logic                          mem_we;
  logic [9:0]                    score;
  logic [15:0]                   state;
  logic [7:0]                    drop_cnt;

  modport master (
    output cmd_valid, command, databyte1, databyte2, re, raddr,
    input  cmd_ready, mem_addr, mem_wdata, mem_we, score, state, drop_cnt
  );

  modport slave (
    input  cmd_valid, command, databyte1, databyte2, re, raddr,
    output cmd_ready, mem_addr, mem_wdata, mem_we, score, state, drop_cnt
  );

endinterface

// File: rtl/gfx_cmd_ctrl_tile_mem_arb.sv
// tile_mem_arb: tile-memory port mux. VGA reads always win; a pending write is
// granted only in cycles with no read request.
module tile_mem_arb
  import gfx_pkg::*;
(
  input  logic               re,
  input  logic [TILE_AW-1:0] raddr,
  input  logic               wr_req,
  input  logic [TILE_AW-1:0] wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic [TILE_AW-1:0] mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_we,
  output logic               grant
);

  // Combinational read-priority mux, no added read latency
  always_comb begin
    grant     = wr_req & ~re;
    mem_we    = grant;
    mem_addr  = re ? raddr : wr_addr;
    mem_wdata = wr_data;
  end

endmodule

// File: rtl/gfx_cmd_ctrl.sv
// gfx_cmd_ctrl: graphics command decoder (score/state registers, tile writes).
// Optional feature macro: GFX_CMD_CTRL_FILL_EN (FILL opcode 0x5, fill counter).
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | cmd_ready=1, capture command bytes on cmd_valid
//   ST_DECODE | execute register ops, or branch to a memory op
//   ST_WRITE  | single tile write, waits while VGA reads
//   ST_FILL   | write color to all 1024 tiles in order (FILL_EN only)
module gfx_cmd_ctrl
  import gfx_pkg::*;
(
  input  logic          clk,
  input  logic          resetB,
  gfx_cmd_ctrl_if.slave bus
);

  fsm_state_e         fsm_q, fsm_d;
  cmd_hold_t          hold_q, hold_d;
  logic [9:0]         score_q, score_d;
  logic [15:0]        state_q, state_d;
  logic [7:0]         drop_q, drop_d;

  logic               wr_req;
  logic [TILE_AW-1:0] wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               grant;

  logic [3:0]         opc;
  logic [TILE_AW-1:0] hold_tile_addr;
  logic               unused_cmd_bit;

  assign opc            = hold_q.command[7:4];
  assign hold_tile_addr = {hold_q.db1[1:0], hold_q.db2};
  assign unused_cmd_bit = hold_q.command[3];

`ifdef GFX_CMD_CTRL_FILL_EN
  logic [TILE_AW-1:0] fill_q, fill_d;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) fsm_q <= ST_IDLE;
    else         fsm_q <= fsm_d;
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:   if (bus.cmd_valid) fsm_d = ST_DECODE;
      ST_DECODE: begin
        case (opc)
          OP_WRITE_TILE: fsm_d = ST_WRITE;
`ifdef GFX_CMD_CTRL_FILL_EN
          OP_FILL:       fsm_d = ST_FILL;
`endif
          default:       fsm_d = ST_IDLE;
        endcase
      end
      ST_WRITE:  if (grant) fsm_d = ST_IDLE;
`ifdef GFX_CMD_CTRL_FILL_EN
      ST_FILL:   if (grant && (fill_q == '1)) fsm_d = ST_IDLE;
`endif
      default:   fsm_d = ST_IDLE;
    endcase
  end

  // FSM outputs: write request toward the arbiter
  always_comb begin
    wr_req  = 1'b0;
    wr_addr = hold_tile_addr;
    wr_data = hold_q.command[COLOR_W-1:0];
    case (fsm_q)
      ST_WRITE: wr_req = 1'b1;
`ifdef GFX_CMD_CTRL_FILL_EN
      ST_FILL: begin
        wr_req  = 1'b1;
        wr_addr = fill_q;
      end
`endif
      default: ;
    endcase
  end

  // Holding register, drop counter and register-type command execution
  always_comb begin
    hold_d  = hold_q;
    score_d = score_q;
    state_d = state_q;
    drop_d  = drop_q;
    if (bus.cmd_valid) begin
      if (fsm_q == ST_IDLE)     hold_d = {bus.command, bus.databyte1, bus.databyte2};
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
    if (fsm_q == ST_DECODE) begin
      case (opc)
        OP_SET_SCORE: score_d = clamp_score({1'b0, hold_tile_addr});
        OP_ADD_SCORE: score_d = clamp_score({1'b0, score_q} + {3'b000, hold_q.db2});
        OP_SET_STATE: state_d = {hold_q.db1, hold_q.db2};
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      hold_q  <= '0;
      score_q <= '0;
      state_q <= '0;
      drop_q  <= '0;
    end else begin
      hold_q  <= hold_d;
      score_q <= score_d;
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

`ifdef GFX_CMD_CTRL_FILL_EN
  // Fill address counter: cleared on entry, steps once per granted write
  always_comb begin
    fill_d = fill_q;
    if (fsm_q == ST_DECODE)              fill_d = '0;
    else if (fsm_q == ST_FILL && grant)  fill_d = fill_q + TILE_AW'(1);
  end

  // Fill counter register
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) fill_q <= '0;
    else         fill_q <= fill_d;
  end
`endif

  tile_mem_arb u_arb (
    .re        (bus.re),
    .raddr     (bus.raddr),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_we    (bus.mem_we),
    .grant     (grant)
  );

  assign bus.cmd_ready = (fsm_q == ST_IDLE);
  assign bus.score     = score_q;
  assign bus.state     = state_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_gfx_cmd_ctrl.sv
// tb_gfx_cmd_ctrl: directed stimulus with scoreboard queues for tile writes and
// command completions. Build with +define+GFX_CMD_CTRL_FILL_EN to cover FILL.
module tb_gfx_cmd_ctrl;
  import gfx_pkg::*;

  logic clk = 1'b0;
  logic resetB;
  always #5 clk = ~clk;

  gfx_cmd_ctrl_if bus();

  gfx_cmd_ctrl u_dut (
    .clk    (clk),
    .resetB (resetB),
    .bus    (bus)
  );

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int score; int st; int drop;} stat_t;

  wr_t   wr_q[$];
  stat_t st_q[$];
  wr_t   wr_exp;
  stat_t st_exp;

  int   total = 0;
  int   bad = 0;
  int   wr_seen = 0;
  int   m_score = 0;
  int   m_state = 0;
  int   m_drop = 0;
  logic prev_ready = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_stat();
    st_q.push_back('{score: m_score, st: m_state, drop: m_drop});
  endtask

  // Assumes we are just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
    bus.cmd_valid = 1'b1;
    bus.command   = c;
    bus.databyte1 = d1;
    bus.databyte2 = d2;
    cyc(1);
    bus.cmd_valid = 1'b0;
  endtask

  function automatic int sat(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  // Monitor: checks read passthrough, pops expected writes and completions
  always @(negedge clk) begin
    if (resetB !== 1'b1) begin
      prev_ready = 1'b1;
    end else begin
      if (bus.re === 1'b1) begin
        chk("rd_we_low", bus.mem_we, 0);
        chk("rd_addr", bus.mem_addr, bus.raddr);
      end
      if (bus.mem_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got write addr=%0d data=%0d required none", bus.mem_addr, bus.mem_wdata);
        end else begin
          wr_exp = wr_q.pop_front();
          chk("wr_addr", bus.mem_addr, wr_exp.addr);
          chk("wr_data", bus.mem_wdata, wr_exp.data);
        end
        wr_seen++;
      end
      if (bus.cmd_ready === 1'b1 && prev_ready === 1'b0) begin
        if (st_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got completion score=%0d required none", bus.score);
        end else begin
          st_exp = st_q.pop_front();
          chk("done_score", bus.score, st_exp.score);
          chk("done_state", bus.state, st_exp.st);
          chk("done_drop", bus.drop_cnt, st_exp.drop);
        end
      end
      prev_ready = bus.cmd_ready;
    end
  end

  // Watchdog
  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL timeout: got no end of test required finish before 500000ns");
    summary();
    $finish;
  end

  initial begin
    int base;
    bus.cmd_valid = 1'b0;
    bus.command   = 8'h00;
    bus.databyte1 = 8'h00;
    bus.databyte2 = 8'h00;
    bus.re        = 1'b0;
    bus.raddr     = '0;
    resetB        = 1'b0;

    cyc(2);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    resetB = 1'b1;
    chk("ready_after_release", bus.cmd_ready, 1);
    cyc(1);
    chk("ready_first_cycle", bus.cmd_ready, 1);

    // SET_SCORE 300 with latency checks
    m_score = 300; push_stat();
    send(8'h20, 8'h01, 8'h2C);
    chk("set_score_early", bus.score, 0);
    chk("decode_not_ready", bus.cmd_ready, 0);
    cyc(1);
    chk("set_score_300", bus.score, 300);
    chk("ready_back", bus.cmd_ready, 1);

    // Saturation boundaries
    m_score = 990; push_stat(); send(8'h20, 8'h03, 8'hDE); cyc(1);
    chk("set_score_990", bus.score, 990);
    m_score = sat(m_score + 32); push_stat(); send(8'h30, 8'h00, 8'h20); cyc(1);
    chk("add_sat_999", bus.score, 999);
    m_score = sat(1023); push_stat(); send(8'h20, 8'h03, 8'hFF); cyc(1);
    chk("set_clamp_999", bus.score, 999);
    m_score = 0; push_stat(); send(8'h20, 8'h00, 8'h00); cyc(1);
    m_score = sat(m_score + 255); push_stat(); send(8'h30, 8'h00, 8'hFF); cyc(1);
    m_score = sat(m_score + 255); push_stat(); send(8'h3F, 8'h00, 8'hFF); cyc(1);
    m_score = sat(m_score + 16);  push_stat(); send(8'h30, 8'hFF, 8'h10); cyc(1);
    chk("add_526", bus.score, 526);

    // SET_STATE
    m_state = 16'hABCD; push_stat(); send(8'h40, 8'hAB, 8'hCD); cyc(1);
    chk("set_state", bus.state, 16'hABCD);

    // No-op opcode
    push_stat(); send(8'h70, 8'hFF, 8'hFF);
    chk("noop_decode", bus.cmd_ready, 0);
    cyc(1);
    chk("noop_ready_2cyc", bus.cmd_ready, 1);
    chk("noop_score", bus.score, 526);
    chk("noop_state", bus.state, 16'hABCD);

    // Back-to-back strobes: second is dropped
    m_score = 100; m_drop = 1; push_stat();
    bus.cmd_valid = 1'b1; bus.command = 8'h20; bus.databyte1 = 8'h00; bus.databyte2 = 8'h64;
    cyc(1);
    bus.databyte2 = 8'hC8;
    cyc(1);
    bus.cmd_valid = 1'b0;
    chk("drop_score", bus.score, 100);
    chk("drop_cnt_1", bus.drop_cnt, 1);

    // WRITE_TILE stalled by VGA reads, plus drop saturation while stalled
    bus.re = 1'b1; bus.raddr = 10'h3A5;
    wr_q.push_back('{addr: 32'h210, data: 5});
    send(8'h15, 8'h02, 8'h10);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      bus.raddr = 10'(32'h100 + i * 37);
      chk("wr_stall_busy", bus.cmd_ready, 0);
      cyc(1);
    end
    bus.cmd_valid = 1'b1; bus.command = 8'h1F; bus.databyte1 = 8'h03; bus.databyte2 = 8'hFF;
    cyc(260);
    bus.cmd_valid = 1'b0;
    m_drop = 255; push_stat();
    chk("drop_sat_255", bus.drop_cnt, 255);
    chk("wr_not_yet", wr_seen, 0);
    bus.re = 1'b0;
    cyc(1);
    chk("wr_done_count", wr_seen, 1);
    cyc(1);

`ifdef GFX_CMD_CTRL_FILL_EN
    // Full fill with re toggling every cycle
    for (int a = 0; a < 1024; a++) wr_q.push_back('{addr: a, data: 3});
    push_stat();
    base = wr_seen;
    send(8'h53, 8'h00, 8'h00);
    for (int i = 0; i < 5000; i++) begin
      if (wr_seen >= base + 1024) break;
      bus.re = ~bus.re;
      cyc(1);
    end
    bus.re = 1'b0;
    cyc(3);
    chk("fill_writes", wr_seen - base, 1024);
    chk("fill_ready", bus.cmd_ready, 1);

    // Fill aborted by reset after 500 writes
    for (int a = 0; a < 500; a++) wr_q.push_back('{addr: a, data: 3});
    base = wr_seen;
    send(8'h53, 8'h00, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      if (wr_seen >= base + 500) break;
      bus.re = ~bus.re;
      cyc(1);
    end
    bus.re = 1'b1;
    resetB = 1'b0;
    m_score = 0; m_state = 0; m_drop = 0;
    cyc(2);
    chk("abort_rst_ready", bus.cmd_ready, 1);
    chk("abort_rst_score", bus.score, 0);
    chk("abort_rst_drop", bus.drop_cnt, 0);
    resetB = 1'b1;
    bus.re = 1'b0;
    cyc(40);
    chk("abort_writes", wr_seen - base, 500);
    chk("abort_idle", bus.cmd_ready, 1);
`else
    // Without the fill feature, 0x53 is a no-op
    push_stat();
    base = wr_seen;
    send(8'h53, 8'h00, 8'h00);
    chk("fill_off_decode", bus.cmd_ready, 0);
    cyc(1);
    chk("fill_off_ready", bus.cmd_ready, 1);
    chk("fill_off_score", bus.score, 100);
    cyc(10);
    chk("fill_off_writes", wr_seen - base, 0);
`endif

    cyc(5);
    chk("wr_q_left", wr_q.size(), 0);
    chk("st_q_left", st_q.size(), 0);
    summary();
    $finish;
  end

endmodule
